// File: rtl/key_event_gen_if.sv
// Key board bundle: raw active-low keys in, debounced level and event pulses out.
interface key_event_gen_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] i_key_n;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_long;
  logic [N_KEYS-1:0] o_repeat;

  modport master (output i_key_n, input o_level, o_press, o_release, o_long, o_repeat);
  modport slave  (input i_key_n, output o_level, o_press, o_release, o_long, o_repeat);
endinterface

// File: rtl/key_event_gen.sv
// Per-key synchronizer, ms debounce, press/release/long/repeat event generator.
// All keys share one 1 kHz tick; every event output is a registered 1-clk pulse.
module key_event_gen #(
  parameter int CLK_HZ      = 50000000,
  parameter int N_KEYS      = 3,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  key_event_gen_if.slave  kif
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [16:0]   DEB_CMP   = 17'(DEBOUNCE_MS);
  localparam logic [16:0]   LONG_CMP  = 17'(LONG_MS);
  localparam logic [16:0]   REP_CMP   = 17'(REPEAT_MS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEB_DN = 3'd1,
    HELD   = 3'd2,
    LONG   = 3'd3,
    DEB_UP = 3'd4
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic reached(input logic [15:0] v, input logic [16:0] lim);
    reached = (({1'b0, v} + 17'd1) == lim);
  endfunction

  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;
  logic          first_hit_s;
  logic [15:0]   deb_first_s;

  // Free-running 1 kHz prescaler shared by all keys
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  assign tick_s      = (tick_cnt_r == TICK_LAST);
  // The cycle in which s_n first changes already counts toward the debounce time.
  assign first_hit_s = tick_s & (DEB_CMP == 17'd1);
  assign deb_first_s = tick_s ? 16'd1 : 16'd0;

  logic [N_KEYS-1:0] level_v_s, press_v_s, release_v_s, long_v_s, repeat_v_s;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [1:0]  sync_r;
    logic        s_n_s;
    state_t      state_r, state_nx_s;
    logic [15:0] deb_cnt_r, deb_cnt_nx_s, hold_cnt_r, hold_cnt_nx_s;
    logic        long_f_r, long_f_nx_s, level_r, level_nx_s;
    logic        press_r, press_nx_s, release_r, release_nx_s;
    logic        long_r, long_nx_s, repeat_r, repeat_nx_s;

    // Two-flop synchronizer; reset value reads as released
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_r <= 2'b11;
      end else begin
        sync_r <= {sync_r[0], kif.i_key_n[k]};
      end
    end

    assign s_n_s = sync_r[1];

    // Key FSM state, counters and registered event outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r    <= IDLE;
        deb_cnt_r  <= 16'd0;
        hold_cnt_r <= 16'd0;
        long_f_r   <= 1'b0;
        level_r    <= 1'b0;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        long_r     <= 1'b0;
        repeat_r   <= 1'b0;
      end else begin
        state_r    <= state_nx_s;
        deb_cnt_r  <= deb_cnt_nx_s;
        hold_cnt_r <= hold_cnt_nx_s;
        long_f_r   <= long_f_nx_s;
        level_r    <= level_nx_s;
        press_r    <= press_nx_s;
        release_r  <= release_nx_s;
        long_r     <= long_nx_s;
        repeat_r   <= repeat_nx_s;
      end
    end

    // Next-state, counter and pulse decode
    always_comb begin
      state_nx_s    = state_r;
      deb_cnt_nx_s  = deb_cnt_r;
      hold_cnt_nx_s = hold_cnt_r;
      long_f_nx_s   = long_f_r;
      level_nx_s    = level_r;
      press_nx_s    = 1'b0;
      release_nx_s  = 1'b0;
      long_nx_s     = 1'b0;
      repeat_nx_s   = 1'b0;
      case (state_r)
        IDLE: begin
          if (!s_n_s && first_hit_s) begin
            state_nx_s    = HELD;
            press_nx_s    = 1'b1;
            level_nx_s    = 1'b1;
            hold_cnt_nx_s = 16'd0;
            long_f_nx_s   = 1'b0;
          end else if (!s_n_s) begin
            state_nx_s   = DEB_DN;
            deb_cnt_nx_s = deb_first_s;
          end else begin
            state_nx_s = IDLE;
          end
        end
        DEB_DN: begin
          if (s_n_s) begin
            state_nx_s = IDLE;
          end else if (tick_s && reached(deb_cnt_r, DEB_CMP)) begin
            state_nx_s    = HELD;
            press_nx_s    = 1'b1;
            level_nx_s    = 1'b1;
            hold_cnt_nx_s = 16'd0;
            long_f_nx_s   = 1'b0;
          end else if (tick_s) begin
            deb_cnt_nx_s = sat_inc(deb_cnt_r);
          end else begin
            deb_cnt_nx_s = deb_cnt_r;
          end
        end
        HELD, LONG: begin
          // Releasing freezes hold_cnt so a rejected glitch resumes where it left off
          if (s_n_s && first_hit_s) begin
            state_nx_s   = IDLE;
            release_nx_s = 1'b1;
            level_nx_s   = 1'b0;
            long_f_nx_s  = 1'b0;
          end else if (s_n_s) begin
            state_nx_s   = DEB_UP;
            deb_cnt_nx_s = deb_first_s;
          end else if (tick_s && (state_r == HELD) && reached(hold_cnt_r, LONG_CMP)) begin
            state_nx_s    = LONG;
            long_nx_s     = 1'b1;
            hold_cnt_nx_s = 16'd0;
            long_f_nx_s   = 1'b1;
          end else if (tick_s && (state_r == LONG) && reached(hold_cnt_r, REP_CMP)) begin
            repeat_nx_s   = 1'b1;
            hold_cnt_nx_s = 16'd0;
          end else if (tick_s) begin
            hold_cnt_nx_s = sat_inc(hold_cnt_r);
          end else begin
            hold_cnt_nx_s = hold_cnt_r;
          end
        end
        DEB_UP: begin
          if (!s_n_s) begin
            state_nx_s = long_f_r ? LONG : HELD;
          end else if (tick_s && reached(deb_cnt_r, DEB_CMP)) begin
            state_nx_s   = IDLE;
            release_nx_s = 1'b1;
            level_nx_s   = 1'b0;
            long_f_nx_s  = 1'b0;
          end else if (tick_s) begin
            deb_cnt_nx_s = sat_inc(deb_cnt_r);
          end else begin
            deb_cnt_nx_s = deb_cnt_r;
          end
        end
        default: begin
          state_nx_s    = IDLE;
          deb_cnt_nx_s  = 16'd0;
          hold_cnt_nx_s = 16'd0;
          long_f_nx_s   = 1'b0;
          level_nx_s    = 1'b0;
        end
      endcase
    end

    assign level_v_s[k]   = level_r;
    assign press_v_s[k]   = press_r;
    assign release_v_s[k] = release_r;
    assign long_v_s[k]    = long_r;
    assign repeat_v_s[k]  = repeat_r;
  end

  assign kif.o_level   = level_v_s;
  assign kif.o_press   = press_v_s;
  assign kif.o_release = release_v_s;
  assign kif.o_long    = long_v_s;
  assign kif.o_repeat  = repeat_v_s;

endmodule
